// File: rtl/sort_pkg.sv
// Shared types for the in-place memory sorter: row count, address/data types, FSM states.
// No logic; imported by mem_sorter and mem_sorter_cmp.
package sort_pkg;
    localparam int NUM_ROWS = 16;
    localparam int ADDR_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef logic [ADDR_W-1:0] t_addr;
    typedef logic [7:0]        t_data;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        FLUSH,
        DONE
    } t_sort_state;
endpackage

// File: rtl/mem_sorter_cmp.sv
// Compare/carry step of the bubble pass: decides the write and the next carried value.
// Latency: purely combinational.
// Backpressure: none; evaluated every SCAN cycle.
module mem_sorter_cmp
    import sort_pkg::*;
#(
    parameter bit DESCENDING = 1'b0
) (
    input  t_data held,
    input  t_data cur,
    input  logic  dirty,
    output logic  wr_en,
    output logic  wr_sel,
    output t_data next_held,
    output logic  swap
);
    logic gt;

    // Strict compare keeps equal rows in place, which makes the sort stable.
    assign gt        = DESCENDING ? (held < cur) : (held > cur);
    assign swap      = gt;
    assign wr_en     = gt | dirty;
    assign wr_sel    = ~gt;
    assign next_held = gt ? held : cur;
endmodule

// File: rtl/mem_sorter.sv
// In-place bubble sorter over a combinational-read / clocked-write memory; MEM_SORTER_EARLY_EXIT_EN stops after a swap-free pass.
// Latency: a pass with limit L takes L+2 cycles (LOAD, L x SCAN, FLUSH); up to NUM_ROWS-1 passes.
// Backpressure: none; start is ignored while busy, done holds until the next accepted start.
module mem_sorter
    import sort_pkg::*;
#(
    parameter int NUM_ROWS   = sort_pkg::NUM_ROWS,
    parameter bit DESCENDING = 1'b0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    output logic  busy,
    output logic  done,
    output t_addr rd_addr,
    input  t_data rd_data,
    output logic  wr_en,
    output t_addr wr_addr,
    output t_data wr_data
);
`ifdef MEM_SORTER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif
    localparam t_addr LAST = t_addr'(NUM_ROWS - 1);

    t_sort_state state, state_nxt;
    t_addr       limit, limit_nxt;
    t_addr       idx, idx_nxt;
    t_data       held, held_nxt;
    logic        dirty, dirty_nxt;
    logic        swapped, swapped_nxt;

    logic  cmp_wr_en;
    logic  cmp_wr_sel;
    t_data cmp_next_held;
    logic  cmp_swap;

    mem_sorter_cmp #(
        .DESCENDING(DESCENDING)
    ) u_cmp (
        .held     (held),
        .cur      (rd_data),
        .dirty    (dirty),
        .wr_en    (cmp_wr_en),
        .wr_sel   (cmp_wr_sel),
        .next_held(cmp_next_held),
        .swap     (cmp_swap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            limit   <= '0;
            idx     <= '0;
            held    <= '0;
            dirty   <= 1'b0;
            swapped <= 1'b0;
        end else begin
            state   <= state_nxt;
            limit   <= limit_nxt;
            idx     <= idx_nxt;
            held    <= held_nxt;
            dirty   <= dirty_nxt;
            swapped <= swapped_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        limit_nxt   = limit;
        idx_nxt     = idx;
        held_nxt    = held;
        dirty_nxt   = dirty;
        swapped_nxt = swapped;
        busy        = 1'b0;
        done        = 1'b0;
        rd_addr     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    limit_nxt = LAST;
                    state_nxt = (NUM_ROWS == 1) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy        = 1'b1;
                rd_addr     = '0;
                held_nxt    = rd_data;
                dirty_nxt   = 1'b0;
                swapped_nxt = 1'b0;
                idx_nxt     = t_addr'(1);
                state_nxt   = SCAN;
            end
            SCAN: begin
                busy    = 1'b1;
                rd_addr = idx;
                // Writes always land one row behind the read, so the two never collide.
                if (cmp_wr_en) begin
                    wr_en   = 1'b1;
                    wr_addr = idx - t_addr'(1);
                    wr_data = cmp_wr_sel ? held : rd_data;
                end
                held_nxt  = cmp_next_held;
                dirty_nxt = cmp_swap;
                if (cmp_swap) begin
                    swapped_nxt = 1'b1;
                end
                if (idx == limit) begin
                    state_nxt = FLUSH;
                end else begin
                    idx_nxt = idx + t_addr'(1);
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (dirty) begin
                    wr_en   = 1'b1;
                    wr_addr = limit;
                    wr_data = held;
                end
                if ((limit == t_addr'(1)) || (EARLY_EXIT && !swapped)) begin
                    state_nxt = DONE;
                end else begin
                    limit_nxt = limit - t_addr'(1);
                    state_nxt = LOAD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    limit_nxt = LAST;
                    state_nxt = (NUM_ROWS == 1) ? DONE : LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_sorter.sv
// Bench for mem_sorter: bubble-sort reference model predicts the write stream, busy time and final image.
module tb_mem_sorter;
    import sort_pkg::*;

    localparam int N = NUM_ROWS;
`ifdef MEM_SORTER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [7:0] INIT_IMG [N] = '{1, 0, 3, 2, 7, 5, 6, 4, 8, 9, 10, 11, 12, 13, 14, 15};

    logic  clk = 1'b0;
    logic  rst_n;
    logic  start;
    logic  busy, done, wr_en;
    t_addr rd_addr, wr_addr;
    t_data rd_data, wr_data;

    logic [7:0] mem      [N];
    logic [7:0] load_img [N];
    logic       load_req;

    int          checks = 0;
    int          fails  = 0;
    int          m [N];
    logic [11:0] exp_q [$];
    logic [11:0] e;
    int          exp_busy, exp_writes;
    int          busy_cnt, wr_cnt;
    bit          running;

    mem_sorter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= load_img[i];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain bubble sort on m[]; a run of consecutive swaps carries one element and costs run+1 writes.
    task automatic build_model();
        bit sw [N];
        bit any;
        int s, ee, tmp, i;
        exp_q.delete();
        exp_busy   = 0;
        exp_writes = 0;
        for (int lim = N - 1; lim >= 1; lim--) begin
            exp_busy += lim + 2;
            any = 1'b0;
            for (int k = 0; k < N; k++) sw[k] = 1'b0;
            for (int k = 1; k <= lim; k++) begin
                if (m[k-1] > m[k]) begin
                    tmp = m[k-1]; m[k-1] = m[k]; m[k] = tmp;
                    sw[k] = 1'b1;
                    any   = 1'b1;
                end
            end
            i = 1;
            while (i <= lim) begin
                if (sw[i]) begin
                    s = i;
                    while (i <= lim && sw[i]) i++;
                    ee = i - 1;
                    for (int p = s - 1; p <= ee; p++) exp_q.push_back({4'(p), 8'(m[p])});
                    exp_writes += ee - s + 2;
                end else begin
                    i++;
                end
            end
            if (EARLY && !any) break;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && running) begin
            if (busy) busy_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(wr_addr), int'(e[11:8]));
                    check("wr_data", int'(wr_data), int'(e[7:0]));
                end
                check("wr_rd_same_addr", int'(wr_addr == rd_addr), 0);
                check("wr_while_busy", int'(busy), 1);
            end
            check("busy_and_done", int'(busy & done), 0);
        end
    end

    task automatic apply_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_sort(input string name, input bit spam, input int pin_writes, input int pin_busy);
        int cyc;
        for (int i = 0; i < N; i++) m[i] = int'(mem[i]);
        build_model();
        if (pin_writes >= 0) check({name, "_model_writes"}, exp_writes, pin_writes);
        if (pin_busy >= 0) check({name, "_model_busy"}, exp_busy, pin_busy);
        busy_cnt = 0;
        wr_cnt   = 0;
        running  = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 4000) begin
            if (spam) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        running = 1'b0;
        check({name, "_timeout"}, int'(cyc >= 4000), 0);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
        check({name, "_writes"}, wr_cnt, exp_writes);
        check({name, "_writes_left"}, exp_q.size(), 0);
        check({name, "_busy_at_done"}, int'(busy), 0);
        for (int i = 0; i < N; i++) check({name, "_row"}, int'(mem[i]), m[i]);
    endtask

    initial begin
        int cnt [256];
        bit perm;
        rst_n    = 1'b0;
        start    = 1'b0;
        load_req = 1'b0;
        running  = 1'b0;
        for (int i = 0; i < N; i++) load_img[i] = INIT_IMG[i];
        apply_load();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        run_sort("init", 1'b0, 12, EARLY ? 62 : 150);
        check("init_done", int'(done), 1);
        run_sort("resort", 1'b0, 0, EARLY ? 17 : 150);

        for (int i = 0; i < N; i++) load_img[i] = INIT_IMG[i];
        apply_load();
        run_sort("spam", 1'b1, 12, EARLY ? 62 : 150);

        for (int i = 0; i < N; i++) load_img[i] = 8'h5A;
        apply_load();
        run_sort("equal", 1'b0, 0, EARLY ? 17 : 150);

        for (int i = 0; i < N; i++) load_img[i] = 8'(N - 1 - i);
        apply_load();
        run_sort("reverse", 1'b0, 135, 150);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++)
                load_img[i] = (t < 3) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            apply_load();
            run_sort("random", (t % 2) == 1, -1, -1);
        end

        for (int i = 0; i < N; i++) load_img[i] = 8'(N - 1 - i);
        apply_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("midsort_rd_addr", int'(rd_addr), 5);
        check("midsort_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_wr_en", int'(wr_en), 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 256; v++) cnt[v] = 0;
        for (int i = 0; i < N; i++) cnt[mem[i]]++;
        perm = 1'b1;
        for (int v = 0; v < N; v++) if (cnt[v] != 1) perm = 1'b0;
        $display("image after abort is a permutation: %0d", perm);
        run_sort("after_abort", 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
